bcd_time_counter: RTL and testbench
===================================

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 400: CLK_400Hz cycles per second tick, legal range 2..65535.
REQ-002 SHALL have port CLK_400Hz, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port run_en, input, 1 bit: 1 = time advances, 0 = prescaler and time frozen.
REQ-005 SHALL have port set_valid, input, 1 bit: a time-load request is present.
REQ-006 SHALL have port set_time, input, 24 bits: {h1,h0,m1,m0,s1,s0}, 4-bit BCD each, MSB first.
REQ-007 SHALL have port set_ready, output, 1 bit: 1 when a load request can be accepted.
REQ-008 SHALL have port set_err, output, 1 bit: the last accepted load was rejected as invalid.
REQ-009 SHALL have port tick_1hz, output, 1 bit: one-cycle pulse on each seconds increment.
REQ-010 SHALL have ports bcd_hrd1, bcd_hrd0, bcd_mind1, bcd_mind0, bcd_secd1, bcd_secd0, outputs, 4 bits each: current hh:mm:ss, registered, feeding the LCD writer directly.

Function
REQ-011 SHALL have a 16-bit prescaler counting 0..CLK_HZ-1 while run_en=1 and state=RUN; at CLK_HZ-1 it wraps to 0 and asserts tick_1hz for that same cycle.
REQ-012 SHALL increment the time by one second in the cycle tick_1hz=1: s0 9->0 carries to s1; s1:s0 59->00 carries to minutes; m 59->00 carries to hours; 23:59:59 wraps to 00:00:00.
REQ-013 SHALL use the FSM states RUN, CHECK and APPLY; set_ready = (state==RUN).
REQ-014 SHALL, in RUN, when set_valid&&set_ready, capture set_time into a shadow register and go to CHECK.
REQ-015 SHALL, in CHECK, mark the shadow register valid iff every digit<=9, s1<=5, m1<=5 and {h1,h0}<=23; valid -> APPLY; invalid -> set_err=1, time unchanged, back to RUN.
REQ-016 SHALL, in APPLY, load the shadow value into the outputs, clear the prescaler and set_err, then return to RUN; new time is visible 2 cycles after the accept edge.
REQ-017 SHALL hold the prescaler in CHECK and APPLY and generate no tick there.
REQ-018 SHALL, when a tick and an accept occur in the same cycle, apply the tick; the load then overwrites it in APPLY.
REQ-019 SHALL keep set_err sticky until the next accepted load completes CHECK.
REQ-020 SHALL, when run_en=0 in RUN, still accept and apply loads.

Reset
REQ-021 SHALL, while reset=1, asynchronously force all digits to 0 (00:00:00), prescaler 0, state RUN, set_err 0, tick_1hz 0; set_ready reads 1.
REQ-022 SHALL discard any load in progress (CHECK/APPLY) when reset is asserted; the first tick comes CLK_HZ cycles after reset release with run_en=1.

Configuration
REQ-023 SHALL, with ALARM_EN defined, add input alarm_time[23:0] (same packing as set_time) and output alarm_out, a one-cycle pulse in the cycle after a tick makes the time equal alarm_time.
REQ-024 SHALL, without ALARM_EN, omit both ports and all alarm logic.
REQ-025 SHALL NOT pulse alarm_out on time changes caused by APPLY.

Structure
REQ-026 SHALL place the FSM state encoding, the BCD limit constants (9, 5, 23) and the digit-field offsets for the 24-bit packing in shared package bcd_clock_pkg.
REQ-027 SHALL build the time from one sub-module, bcd_mod_counter: a two-digit BCD counter with a modulus parameter (60 or 24), an inc input, a load input and a carry output, instantiated three times.

Verification (CLK_HZ=4 unless noted)
REQ-028 SHALL check reset then run_en=1: tick_1hz pulses every 4 cycles and time reads 00:00:03 after 12 cycles.
REQ-029 SHALL check load 23:59:58 then 2 ticks: 23:59:59 then 00:00:00, with carry through all six digits in one cycle.
REQ-030 SHALL check load 24:00:00 or 12:60:00: set_err=1 one cycle after CHECK and time unchanged; a later valid load of 12:34:56 clears set_err and shows 12:34:56 at accept+2.
REQ-031 SHALL check set_valid held during CHECK/APPLY: set_ready=0, no second capture, prescaler frozen for 2 cycles.
REQ-032 SHALL check reset asserted mid-CHECK with 10:00:00 pending: outputs 00:00:00 and the load is discarded.
REQ-033 SHALL check, with ALARM_EN, alarm_time=00:00:02 from reset: one alarm_out pulse 1 cycle after the second tick, and none when 00:00:02 is loaded directly.

Source files
------------

// File: rtl/bcd_clock_pkg.sv
// Shared definitions for the BCD time-of-day counter: FSM encoding, BCD limits,
// digit-field offsets for the packed {h1,h0,m1,m0,s1,s0} word and a validity check.
package bcd_clock_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StCheck = 2'd1,
        StApply = 2'd2
    } state_e;

    // BCD limits
    localparam logic [3:0] DigitMax = 4'd9;
    localparam logic [3:0] TensMax  = 4'd5;
    localparam logic [7:0] HourMax  = 8'd23;

    // LSB offsets of each 4-bit digit in the 24-bit packed time word
    localparam int unsigned S0Lsb = 0;
    localparam int unsigned S1Lsb = 4;
    localparam int unsigned M0Lsb = 8;
    localparam int unsigned M1Lsb = 12;
    localparam int unsigned H0Lsb = 16;
    localparam int unsigned H1Lsb = 20;

    // True when the packed word is a legal hh:mm:ss in 24-hour BCD
    function automatic logic time_is_valid(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        logic [7:0] hours;
        h1 = t[H1Lsb +: 4];
        h0 = t[H0Lsb +: 4];
        m1 = t[M1Lsb +: 4];
        m0 = t[M0Lsb +: 4];
        s1 = t[S1Lsb +: 4];
        s0 = t[S0Lsb +: 4];
        hours = ({4'd0, h1} * 8'd10) + {4'd0, h0};
        return (h1 <= DigitMax) && (h0 <= DigitMax) && (m1 <= DigitMax) &&
               (m0 <= DigitMax) && (s1 <= DigitMax) && (s0 <= DigitMax) &&
               (s1 <= TensMax) && (m1 <= TensMax) && (hours <= HourMax);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MODULUS (60 for seconds/minutes, 24 for hours).
// load has priority over inc; carry flags the wrap cycle so the next stage can advance.
module bcd_mod_counter
    import bcd_clock_pkg::*;
#(
    parameter int unsigned MODULUS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       carry
);

    localparam logic [3:0] TopHi = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] TopLo = 4'((MODULUS - 1) % 10);

    logic [3:0] d1_q, d1_d, d0_q, d0_d;
    logic       at_top;

    assign at_top = (d1_q == TopHi) && (d0_q == TopLo);
    assign carry  = inc && at_top && !load;
    assign d1     = d1_q;
    assign d0     = d0_q;

    // Next value: load, else BCD increment with wrap at MODULUS-1
    always_comb begin
        d1_d = d1_q;
        d0_d = d0_q;
        if (load) begin
            d1_d = load_val[7:4];
            d0_d = load_val[3:0];
        end else if (inc) begin
            if (at_top) begin
                d1_d = 4'd0;
                d0_d = 4'd0;
            end else if (d0_q == DigitMax) begin
                d1_d = d1_q + 4'd1;
                d0_d = 4'd0;
            end else begin
                d0_d = d0_q + 4'd1;
            end
        end
    end

    // Digit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q <= 4'd0;
            d0_q <= 4'd0;
        end else begin
            d1_q <= d1_d;
            d0_q <= d0_d;
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss time-of-day counter with a 1 Hz prescaler and a checked time-load path
// (RUN -> CHECK -> APPLY). Define ALARM_EN to add the alarm_time input and alarm_out pulse.
module bcd_time_counter
    import bcd_clock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 400
) (
    input  logic        CLK_400Hz,
    input  logic        reset,
    input  logic        run_en,
    input  logic        set_valid,
    input  logic [23:0] set_time,
    output logic        set_ready,
    output logic        set_err,
    output logic        tick_1hz,
`ifdef ALARM_EN
    input  logic [23:0] alarm_time,
    output logic        alarm_out,
`endif
    output logic [3:0]  bcd_hrd1,
    output logic [3:0]  bcd_hrd0,
    output logic [3:0]  bcd_mind1,
    output logic [3:0]  bcd_mind0,
    output logic [3:0]  bcd_secd1,
    output logic [3:0]  bcd_secd0
);

    localparam logic [15:0] PrescTop = 16'(CLK_HZ - 1);

    state_e      state_q, state_d;
    logic [15:0] presc_q;
    logic [23:0] shadow_q;
    logic        set_err_q;
    logic        shadow_ok;
    logic        accept;
    logic        presc_en;
    logic        tick;
    logic        apply;
    logic        sec_carry, min_carry, day_wrap_unused;

    assign shadow_ok = time_is_valid(shadow_q);
    assign set_err   = set_err_q;
    assign tick_1hz  = tick;

    // FSM state register
    always_ff @(posedge CLK_400Hz or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (set_valid) state_d = StCheck;
            StCheck: state_d = shadow_ok ? StApply : StRun;
            StApply: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // FSM outputs; the prescaler only runs (and can only tick) in RUN
    always_comb begin
        set_ready = (state_q == StRun);
        accept    = set_ready && set_valid;
        presc_en  = run_en && (state_q == StRun);
        tick      = presc_en && (presc_q == PrescTop);
        apply     = (state_q == StApply);
    end

    // Prescaler: cleared by a load so the first second after it is a full one
    always_ff @(posedge CLK_400Hz or posedge reset) begin
        if (reset) begin
            presc_q <= 16'd0;
        end else if (apply) begin
            presc_q <= 16'd0;
        end else if (presc_en) begin
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;
        end
    end

    // Shadow capture of the requested time on accept
    always_ff @(posedge CLK_400Hz or posedge reset) begin
        if (reset) begin
            shadow_q <= 24'd0;
        end else if (accept) begin
            shadow_q <= set_time;
        end
    end

    // Error flag: decided at CHECK, sticky until the next load is checked
    always_ff @(posedge CLK_400Hz or posedge reset) begin
        if (reset) begin
            set_err_q <= 1'b0;
        end else if (state_q == StCheck) begin
            set_err_q <= !shadow_ok;
        end else if (apply) begin
            set_err_q <= 1'b0;
        end
    end

    bcd_mod_counter #(
        .MODULUS (60)
    ) u_sec (
        .clk      (CLK_400Hz),
        .rst      (reset),
        .inc      (tick),
        .load     (apply),
        .load_val (shadow_q[S0Lsb +: 8]),
        .d1       (bcd_secd1),
        .d0       (bcd_secd0),
        .carry    (sec_carry)
    );

    bcd_mod_counter #(
        .MODULUS (60)
    ) u_min (
        .clk      (CLK_400Hz),
        .rst      (reset),
        .inc      (sec_carry),
        .load     (apply),
        .load_val (shadow_q[M0Lsb +: 8]),
        .d1       (bcd_mind1),
        .d0       (bcd_mind0),
        .carry    (min_carry)
    );

    // Hour wrap needs no further stage: 23:59:59 simply rolls to 00:00:00
    bcd_mod_counter #(
        .MODULUS (24)
    ) u_hr (
        .clk      (CLK_400Hz),
        .rst      (reset),
        .inc      (min_carry),
        .load     (apply),
        .load_val (shadow_q[H0Lsb +: 8]),
        .d1       (bcd_hrd1),
        .d0       (bcd_hrd0),
        .carry    (day_wrap_unused)
    );

`ifdef ALARM_EN
    logic tick_d1_q;

    // Remember a tick so the match is only judged on tick-driven time changes
    always_ff @(posedge CLK_400Hz or posedge reset) begin
        if (reset) begin
            tick_d1_q <= 1'b0;
        end else begin
            tick_d1_q <= tick;
        end
    end

    assign alarm_out = tick_d1_q &&
        ({bcd_hrd1, bcd_hrd0, bcd_mind1, bcd_mind0, bcd_secd1, bcd_secd0} == alarm_time);
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter at CLK_HZ=4; inputs driven and outputs sampled
// on the falling clock edge. Define ALARM_EN to cover the alarm feature as well.
module tb_bcd_time_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_en;
    logic        set_valid;
    logic [23:0] set_time;
    logic        set_ready;
    logic        set_err;
    logic        tick_1hz;
    logic [3:0]  bcd_hrd1, bcd_hrd0, bcd_mind1, bcd_mind0, bcd_secd1, bcd_secd0;
`ifdef ALARM_EN
    logic [23:0] alarm_time;
    logic        alarm_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_time_counter #(
        .CLK_HZ (4)
    ) dut (
        .CLK_400Hz  (clk),
        .reset      (reset),
        .run_en     (run_en),
        .set_valid  (set_valid),
        .set_time   (set_time),
        .set_ready  (set_ready),
        .set_err    (set_err),
        .tick_1hz   (tick_1hz),
`ifdef ALARM_EN
        .alarm_time (alarm_time),
        .alarm_out  (alarm_out),
`endif
        .bcd_hrd1   (bcd_hrd1),
        .bcd_hrd0   (bcd_hrd0),
        .bcd_mind1  (bcd_mind1),
        .bcd_mind0  (bcd_mind0),
        .bcd_secd1  (bcd_secd1),
        .bcd_secd0  (bcd_secd0)
    );

    function automatic logic [23:0] now_time();
        return {bcd_hrd1, bcd_hrd0, bcd_mind1, bcd_mind0, bcd_secd1, bcd_secd0};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a load for one cycle; returns at the falling edge of the CHECK cycle
    task automatic load(input logic [23:0] t);
        set_time  = t;
        set_valid = 1'b1;
        wait_neg(1);
        set_valid = 1'b0;
    endtask

    initial begin
        int ticks;
        reset     = 1'b1;
        run_en    = 1'b0;
        set_valid = 1'b0;
        set_time  = 24'h0;
`ifdef ALARM_EN
        alarm_time = 24'h000002;
`endif
        wait_neg(2);
        check("rst_time", now_time(), 24'h000000);
        check("rst_ready", set_ready, 1'b1);
        check("rst_err", set_err, 1'b0);
        check("rst_tick", tick_1hz, 1'b0);

        // Free run: tick every 4 cycles, 00:00:03 after 12 cycles
        reset  = 1'b0;
        run_en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            wait_neg(1);
            check("run_tick", tick_1hz, (i % 4) == 3);
`ifdef ALARM_EN
            check("alarm_tick", alarm_out, i == 8);
`endif
        end
        check("run_time", now_time(), 24'h000003);

        // Load 23:59:58 with set_valid held through CHECK/APPLY
        set_time  = 24'h235958;
        set_valid = 1'b1;
        wait_neg(1);
        set_time = 24'h111111;
        check("chk_ready", set_ready, 1'b0);
        check("chk_presc", dut.presc_q, 24'd1);
        wait_neg(1);
        check("apl_ready", set_ready, 1'b0);
        check("apl_presc", dut.presc_q, 24'd1);
        check("apl_time_old", now_time(), 24'h000003);
        wait_neg(1);
        set_valid = 1'b0;
        check("load_time", now_time(), 24'h235958);
        check("load_ready", set_ready, 1'b1);
        wait_neg(3);
        check("wrap_tick1", tick_1hz, 1'b1);
        check("wrap_pre1", now_time(), 24'h235958);
        wait_neg(1);
        check("wrap_t59", now_time(), 24'h235959);
        check("wrap_notick", tick_1hz, 1'b0);
        wait_neg(3);
        check("wrap_tick2", tick_1hz, 1'b1);
        wait_neg(1);
        check("wrap_t00", now_time(), 24'h000000);

        // Invalid loads set a sticky error, time unchanged
        load(24'h240000);
        check("bad_err_chk", set_err, 1'b0);
        wait_neg(1);
        check("bad_err_h", set_err, 1'b1);
        check("bad_time_h", now_time(), 24'h000000);
        check("bad_ready", set_ready, 1'b1);
        load(24'h126000);
        wait_neg(1);
        check("bad_err_m", set_err, 1'b1);
        check("bad_time_m", now_time(), 24'h000000);

        // Valid load clears the error, new time at accept+2
        load(24'h123456);
        check("good_chk_time", now_time(), 24'h000000);
        wait_neg(1);
        check("good_apl_time", now_time(), 24'h000000);
        wait_neg(1);
        check("good_time", now_time(), 24'h123456);
        check("good_err", set_err, 1'b0);

        // Tick and accept in the same cycle: tick first, load wins
        wait_neg(3);
        check("both_tick", tick_1hz, 1'b1);
        set_time  = 24'h010203;
        set_valid = 1'b1;
        wait_neg(1);
        set_valid = 1'b0;
        check("both_ticked", now_time(), 24'h123457);
        wait_neg(2);
        check("both_loaded", now_time(), 24'h010203);

        // Loads still work while stopped; time stays frozen
        run_en = 1'b0;
        load(24'h095959);
        wait_neg(2);
        check("stop_load", now_time(), 24'h095959);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            wait_neg(1);
            if (tick_1hz) ticks++;
        end
        check("stop_ticks", ticks, 0);
        check("stop_time", now_time(), 24'h095959);

        // Reset during CHECK discards the pending load
        run_en = 1'b1;
        load(24'h100000);
        reset = 1'b1;
        #1;
        check("mid_rst_time", now_time(), 24'h000000);
        check("mid_rst_ready", set_ready, 1'b1);
        wait_neg(2);
        reset = 1'b0;
        wait_neg(3);
        check("post_rst_tick", tick_1hz, 1'b1);
        check("post_rst_time", now_time(), 24'h000000);
        wait_neg(1);
        check("post_rst_t1", now_time(), 24'h000001);

`ifdef ALARM_EN
        // Loading the alarm time directly must not fire the alarm
        reset  = 1'b1;
        run_en = 1'b0;
        wait_neg(1);
        reset = 1'b0;
        load(24'h000002);
        check("alarm_load0", alarm_out, 1'b0);
        wait_neg(1);
        check("alarm_load1", alarm_out, 1'b0);
        wait_neg(1);
        check("alarm_load2", alarm_out, 1'b0);
        check("alarm_ld_time", now_time(), 24'h000002);
        wait_neg(1);
        check("alarm_load3", alarm_out, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
